// File: rtl/ppu_pkg.sv
// Shared PPU-side constants: CPU-visible register addresses and the OAM DMA state encoding.
package ppu_pkg;

    localparam logic [15:0] ADDR_OAMDMA  = 16'h4014;
    localparam logic [15:0] ADDR_OAMDATA = 16'h2004;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HALT  = 3'd1;
    localparam logic [2:0] ST_ALIGN = 3'd2;
    localparam logic [2:0] ST_READ  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        HALT  = ST_HALT,
        ALIGN = ST_ALIGN,
        READ  = ST_READ,
        WRITE = ST_WRITE
    } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// Sprite OAM DMA engine for $4014: halts the CPU and copies one page to OAMDATA
// as read/write bus cycle pairs.
module oam_dma
    import ppu_pkg::*;
#(
    parameter int XFER_LEN = 256,
    parameter bit ALIGN_EN = 1'b1
) (
    input  logic        i_cpu_clk,
    input  logic        i_cpu_rstn,
    input  logic [15:0] i_bus_addr,
    input  logic        i_bus_wn,
    input  logic [7:0]  i_bus_wdata,
    input  logic [7:0]  i_dma_rdata,
    output logic        o_cpu_rdy,
    output logic        o_dma_busy,
    output logic [15:0] o_dma_addr,
    output logic        o_dma_wn,
    output logic [7:0]  o_dma_wdata
);

    localparam int              CNT_W = $clog2(XFER_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XFER_LEN - 1);

    dma_state_t       state, state_nxt;
    logic [7:0]       page;
    logic [7:0]       data_q;
    logic [CNT_W-1:0] count;
    logic [7:0]       count_byte;
    logic             parity;
    logic             trigger;

    // Only an idle engine accepts a page write; later writes are dropped.
    assign trigger    = (state == IDLE) && (i_bus_addr == ADDR_OAMDMA) && !i_bus_wn;
    assign count_byte = 8'(count);

    always_ff @(posedge i_cpu_clk) begin
        if (!i_cpu_rstn) begin
            state  <= IDLE;
            page   <= 8'h00;
            data_q <= 8'h00;
            count  <= '0;
            parity <= 1'b0;
        end else begin
            state  <= state_nxt;
            parity <= ~parity;
            if (trigger)
                page <= i_bus_wdata;
            if (state == READ)
                data_q <= i_dma_rdata;
            if (state == WRITE)
                count <= (count == LAST) ? '0 : count + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt   = state;
        o_cpu_rdy   = 1'b1;
        o_dma_busy  = 1'b0;
        o_dma_addr  = 16'h0000;
        o_dma_wn    = 1'b1;
        o_dma_wdata = 8'h00;
        case (state)
            IDLE: begin
                if (trigger)
                    state_nxt = HALT;
            end
            HALT: begin
                o_cpu_rdy  = 1'b0;
                o_dma_busy = 1'b1;
                o_dma_addr = ADDR_OAMDMA;
                // Reads must start on an even CPU cycle, so burn one cycle when odd.
                state_nxt  = (ALIGN_EN && parity) ? ALIGN : READ;
            end
            ALIGN: begin
                o_cpu_rdy  = 1'b0;
                o_dma_busy = 1'b1;
                o_dma_addr = ADDR_OAMDMA;
                state_nxt  = READ;
            end
            READ: begin
                o_cpu_rdy  = 1'b0;
                o_dma_busy = 1'b1;
                o_dma_addr = {page, count_byte};
                state_nxt  = WRITE;
            end
            WRITE: begin
                o_cpu_rdy   = 1'b0;
                o_dma_busy  = 1'b1;
                o_dma_addr  = ADDR_OAMDATA;
                o_dma_wn    = 1'b0;
                o_dma_wdata = data_q;
                state_nxt   = (count == LAST) ? IDLE : READ;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: cycle-exact bus sequence checks against a bench-side
// memory/OAM model, covering parity alignment, retrigger, page $FF and mid-transfer reset.
module tb_oam_dma;

    logic        clk;
    logic        rstn;
    logic [15:0] bus_addr;
    logic        bus_wn;
    logic [7:0]  bus_wdata;
    logic [7:0]  dma_rdata;
    logic        cpu_rdy;
    logic        dma_busy;
    logic [15:0] dma_addr;
    logic        dma_wn;
    logic [7:0]  dma_wdata;

    int n_vec = 0;
    int n_err = 0;

    bit         ph;
    logic [7:0] oam [256];
    logic [7:0] oamaddr;
    bit         page0_hit;

    oam_dma #(.XFER_LEN(256), .ALIGN_EN(1'b1)) dut (
        .i_cpu_clk   (clk),
        .i_cpu_rstn  (rstn),
        .i_bus_addr  (bus_addr),
        .i_bus_wn    (bus_wn),
        .i_bus_wdata (bus_wdata),
        .i_dma_rdata (dma_rdata),
        .o_cpu_rdy   (cpu_rdy),
        .o_dma_busy  (dma_busy),
        .o_dma_addr  (dma_addr),
        .o_dma_wn    (dma_wn),
        .o_dma_wdata (dma_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: every byte holds its low address bits XOR A5.
    assign dma_rdata = dma_addr[7:0] ^ 8'hA5;

    // Reference copy of the CPU-cycle parity and a PPU-side OAM/OAMADDR model.
    always @(posedge clk) begin
        if (!rstn) begin
            ph      <= 1'b0;
            oamaddr <= 8'h00;
        end else begin
            ph <= ~ph;
            if (!dma_wn && dma_addr == 16'h2004) begin
                oam[oamaddr] <= dma_wdata;
                oamaddr      <= oamaddr + 8'd1;
            end
        end
    end

    always @(negedge clk)
        if (dma_busy && dma_addr[15:8] == 8'h00)
            page0_hit <= 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [26:0] pack_out();
        return {cpu_rdy, dma_busy, dma_addr, dma_wn, dma_wdata};
    endfunction

    localparam logic [26:0] IDLE_OUT = {1'b1, 1'b0, 16'h0000, 1'b1, 8'h00};

    // Triggers a DMA of page pg with the HALT cycle on the requested parity and checks
    // every cycle. retrig: cycle index at which to drive a $4014 write of 8'h03.
    // abort_at: cycle index at which to pulse reset and stop.
    task automatic run_dma(input logic [7:0] pg, input bit odd, input int retrig, input int abort_at);
        int          a;
        int          total;
        int          n_busy;
        int          j;
        logic [7:0]  i8;
        logic [26:0] exp;
        a     = odd ? 1 : 0;
        total = 1 + a + 512;
        // HALT parity equals the inverse of the parity seen before the trigger edge.
        for (int w = 0; w < 2 && ph == odd; w++) @(negedge clk);
        bus_addr  = 16'h4014;
        bus_wn    = 1'b0;
        bus_wdata = pg;
        @(negedge clk);
        bus_addr  = 16'h0000;
        bus_wn    = 1'b1;
        bus_wdata = 8'h00;
        n_busy    = 0;
        for (int k = 0; k < total; k++) begin
            if (k <= a) begin
                exp = {1'b0, 1'b1, 16'h4014, 1'b1, 8'h00};
            end else begin
                j  = k - 1 - a;
                i8 = 8'(j / 2);
                if (j % 2 == 0)
                    exp = {1'b0, 1'b1, pg, i8, 1'b1, 8'h00};
                else
                    exp = {1'b0, 1'b1, 16'h2004, 1'b0, i8 ^ 8'hA5};
            end
            check($sformatf("cycle%0d_pg%02h", k, pg), 32'(pack_out()), 32'(exp));
            if (!cpu_rdy) n_busy++;
            if (k == abort_at) begin
                rstn = 1'b0;
                @(negedge clk);
                check("reset_midxfer_idle", 32'(pack_out()), 32'(IDLE_OUT));
                rstn = 1'b1;
                return;
            end
            if (k == retrig) begin
                bus_addr  = 16'h4014;
                bus_wn    = 1'b0;
                bus_wdata = 8'h03;
            end else begin
                bus_addr  = 16'h0000;
                bus_wn    = 1'b1;
                bus_wdata = 8'h00;
            end
            @(negedge clk);
        end
        bus_addr  = 16'h0000;
        bus_wn    = 1'b1;
        bus_wdata = 8'h00;
        check("busy_cycles", 32'(n_busy), 32'(total));
        check("idle_after_1", 32'(pack_out()), 32'(IDLE_OUT));
        @(negedge clk);
        check("idle_after_2", 32'(pack_out()), 32'(IDLE_OUT));
    endtask

    initial begin
        rstn      = 1'b0;
        bus_addr  = 16'h0000;
        bus_wn    = 1'b1;
        bus_wdata = 8'h00;
        page0_hit = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'(pack_out()), 32'(IDLE_OUT));
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_trigger", 32'(pack_out()), 32'(IDLE_OUT));

        // Even-parity start, also exercising the OAM model end to end.
        run_dma(8'h02, 1'b0, -1, -1);
        check("oam_00", 32'(oam[8'h00]), 32'(8'hA5));
        check("oam_7f", 32'(oam[8'h7F]), 32'(8'hDA));
        check("oam_ff", 32'(oam[8'hFF]), 32'(8'h5A));
        check("oamaddr_wrap", 32'(oamaddr), 32'(8'h00));

        // Odd-parity start inserts one ALIGN cycle.
        run_dma(8'h02, 1'b1, -1, -1);

        // Retrigger mid-transfer is ignored.
        run_dma(8'h02, 1'b0, 100, -1);

        // $4014 write on the final WRITE edge is ignored too.
        run_dma(8'h02, 1'b1, 513, -1);

        // Page $FF: no carry into the page, no access to page 0.
        page0_hit = 1'b0;
        run_dma(8'hFF, 1'b0, -1, -1);
        check("page_ff_no_page0", 32'(page0_hit), 32'(1'b0));

        // Reset during READ of count 40, then a clean restart from count 0.
        run_dma(8'h02, 1'b0, -1, 81);
        @(negedge clk);
        check("post_reset_idle", 32'(pack_out()), 32'(IDLE_OUT));
        run_dma(8'h02, 1'b0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
- Sprite OAM DMA engine for CPU register $4014. Sits upstream of the PPU register block on the CPU bus.
- A CPU write of page P to $4014 halts the CPU. The engine then copies 256 bytes from $PP00-$PPFF to $2004 (OAMDATA) as read/write bus cycle pairs, and releases the CPU when done.
- An external bus mux (outside this block) selects the DMA address, write-strobe and data over the CPU's while o_dma_busy is high.

Parameters:
- XFER_LEN, 256: bytes per transfer. The counter is log2(XFER_LEN) bits wide.
- ALIGN_EN, 1: when 1, insert one alignment cycle if the halt cycle lands on an odd CPU cycle.

Ports:
- i_cpu_clk, in, 1: CPU clock.
- i_cpu_rstn, in, 1: reset.
- i_bus_addr, in, 16: CPU bus address, as driven by the CPU.
- i_bus_wn, in, 1: CPU write strobe, active low.
- i_bus_wdata, in, 8: CPU write data.
- i_dma_rdata, in, 8: read data from the bus at o_dma_addr, valid by the end of the read cycle.
- o_cpu_rdy, out, 1: 0 halts the CPU.
- o_dma_busy, out, 1: bus mux select; 1 means the DMA owns the bus.
- o_dma_addr, out, 16: DMA bus address.
- o_dma_wn, out, 1: DMA write strobe, active low.
- o_dma_wdata, out, 8: DMA write data.

Interface rule (already decided):
- One clock, i_cpu_clk.
- Reset i_cpu_rstn is synchronous and active-low.

Behaviour:
- Reset values: o_cpu_rdy=1, o_dma_busy=0, o_dma_addr=16'h0000, o_dma_wn=1, o_dma_wdata=8'h00. Also state=IDLE, page=0, count=0, data latch=0, parity=0.
- Parity: a 1-bit register that toggles every cycle once reset is released. It marks even/odd CPU cycles.
- Trigger: in IDLE, if i_bus_addr==16'h4014 and i_bus_wn==0 at a posedge:
  - latch page <= i_bus_wdata;
  - state <= HALT.
  - The CPU's own write cycle completes normally.
- Retrigger: writes to $4014 while state is not IDLE are ignored; page is unchanged.
- HALT (1 cycle): o_cpu_rdy=0, o_dma_busy=1, o_dma_wn=1, o_dma_addr=16'h4014. Next state:
  - ALIGN if ALIGN_EN and parity==1;
  - otherwise READ.
- ALIGN (1 cycle): same outputs as HALT. Next state is READ.
- READ: o_dma_addr={page,count}, o_dma_wn=1. The posedge ending READ samples i_dma_rdata into the data latch. Next state is WRITE.
- WRITE: o_dma_addr=16'h2004, o_dma_wn=0, o_dma_wdata=data latch. The PPU commits the OAM write and post-increments OAMADDR at that posedge. Then:
  - if count==XFER_LEN-1: count <= 0, state <= IDLE;
  - otherwise: count <= count+1, state <= READ.
- Busy/ready: o_cpu_rdy=0 and o_dma_busy=1 in every non-IDLE state. On the first cycle back in IDLE, o_cpu_rdy=1 and o_dma_busy=0.
- Output timing: all outputs are decoded combinationally from registered state only, never from the bus inputs. In IDLE they hold their reset values.
- Latency: write accepted at edge T, then HALT starts at T+1. Total non-IDLE cycles are 1 + align + 2*XFER_LEN, i.e. 513 or 514.
- Address width: the low byte of the read address is exactly count, so page $FF reads $FF00-$FFFF with no carry into the page.
- No wrap: count never wraps mid-transfer; the transfer ends exactly at count==XFER_LEN-1.
- Reset mid-transfer: returns to the full reset state on the next posedge. The partial transfer is abandoned, the CPU is released, and there is no resume.
- Simultaneous events: a $4014 write on the same edge the engine returns to IDLE is ignored, because state is not IDLE at that edge.

Decomposition:
- Shared package ppu_pkg:
  - constants ADDR_OAMDMA=16'h4014, ADDR_OAMDATA=16'h2004;
  - state encoding IDLE/HALT/ALIGN/READ/WRITE as 3-bit localparams.
- Single module, no sub-module. The bus mux lives in the console top level.

Test Plan:
- Even-parity start: write 8'h02 to $4014 with parity==0 -> o_cpu_rdy low for exactly 513 cycles. Reads $0200..$02FF in order; 256 writes to $2004 with wdata equal to memory contents (preloaded as addr[7:0]^8'hA5).
- Odd-parity start: same as above but with parity==1 -> exactly 514 busy cycles, one ALIGN cycle with o_dma_wn=1 before the first READ; data identical.
- Retrigger: write 8'h03 to $4014 at cycle 100 of a transfer of page 8'h02 -> ignored. All reads stay in $02xx; total length unchanged.
- Page $FF: write 8'hFF -> last read address is $FFFF, no access to $0000; then o_cpu_rdy=1 and o_dma_busy=0.
- Reset mid-transfer: assert i_cpu_rstn=0 for 1 cycle during READ of count 40 -> next cycle o_cpu_rdy=1, o_dma_busy=0, o_dma_wn=1. A new $4014 write afterwards restarts at count 0.
- End-to-end with the PPU register block: set OAMADDR=0, DMA page 8'h02 -> OAM[i]==mem[$0200+i] for all i, and OAMADDR ends at 8'h00.
